ps2_mouse_tracker: RTL and testbench
====================================

Name: ps2_mouse_tracker

Overview:
- Parametrised PS/2 mouse packet decoder and cursor tracker.
- Sits between the PS/2 byte receiver (data byte + 1-cycle enable strobe) and the VGA/game logic.
- Assembles standard 3-byte packets with resync and inter-byte timeout.
- Accumulates signed X/Y deltas into a clamped screen position, exports button levels and click pulses.
- Supersedes the fixed-size mouse code-to-signal path: configurable screen size and start point, overflow handling, framing recovery.

Parameters:
- X_WIDTH, 9, width of x_position
- Y_WIDTH, 8, width of y_position
- X_MAX, 319, largest legal x (inclusive)
- Y_MAX, 239, largest legal y (inclusive)
- X_INIT, 160, x after reset
- Y_INIT, 120, y after reset
- TIMEOUT_CYCLES, 100000, max idle cycles between bytes of one packet (2 ms at 50 MHz)
- ACCEL_THRESH, 8, |delta| above which acceleration applies (MOUSE_ACCEL_EN only)

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- received_data  in  8  byte from PS/2 receiver
- received_data_en  in  1  one-cycle strobe, received_data valid
- x_position  out  X_WIDTH  cursor x, 0..X_MAX
- y_position  out  Y_WIDTH  cursor y, 0..Y_MAX, 0 = top row
- left_down / right_down / middle_down  out  1 each  button levels from last good packet
- left_click  out  1  one-cycle pulse on left 0->1 transition
- packet_valid  out  1  one-cycle pulse when a packet is applied
- sync_error  out  1  one-cycle pulse when a byte is discarded for framing

Behaviour:
- Reset: asynchronous, active-high. Sets:
  - x_position=X_INIT, y_position=Y_INIT
  - all buttons 0, all pulses 0
  - FSM=WAIT_B0, timeout counter 0
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2. Bytes are consumed only on received_data_en.
- WAIT_B0:
  - If bit3=1: latch as status byte, go to WAIT_B1.
  - Else: pulse sync_error, stay in WAIT_B0.
- WAIT_B1: latch dx byte, go to WAIT_B2.
- WAIT_B2, on strobe:
  - Compute the update and go to WAIT_B0.
  - Next clock edge registers position and buttons and pulses packet_valid (latency 1 cycle after the third strobe).
- Timeout:
  - Counter clears on every accepted byte and increments each cycle while in WAIT_B1/WAIT_B2.
  - On reaching TIMEOUT_CYCLES-1: return to WAIT_B0, discard the partial packet, pulse sync_error.
  - A strobe arriving in the same cycle as expiry is consumed as the current state's byte; the timeout loses.
- Delta decode:
  - dx = {status[4], byte1} as 9-bit two's complement; dy = {status[5], byte2}.
  - status[6] (X overflow) forces dx=0; status[7] (Y overflow) forces dy=0.
- Arithmetic:
  - new_x = x + dx, computed in X_WIDTH+2 signed bits.
  - new_y = y - dy, computed in Y_WIDTH+2 signed bits. PS/2 +Y is up; screen +Y is down.
  - Clamp: result < 0 -> 0; result > MAX -> MAX. No wrap-around ever.
- Buttons:
  - left = status[0], right = status[1], middle = status[2]; updated only with packet_valid.
  - left_click = packet_valid AND new left AND NOT previous left.
- Back-to-back packets at minimum strobe spacing (1 cycle apart) must be handled with no byte lost.
- Reset mid-packet abandons the packet; no partial update is applied.

Optional Feature:
- Macro: MOUSE_ACCEL_EN.
- Defined: a delta with |d| > ACCEL_THRESH is doubled (sign preserved) before accumulation, then clamped as normal.
- Undefined: deltas applied 1:1; ACCEL_THRESH unused.

Decomposition:
- Package ps2_mouse_pkg holds:
  - FSM state encoding
  - status-bit index constants: BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XS=4, YS=5, XO=6, YO=7
  - packet length constant 3
- One sub-module, ps2_axis_accum, instantiated twice (X and Y), parametrised by width, max, init and direction.
  - Inputs: 9-bit delta, overflow flag, apply strobe.
  - Performs optional acceleration, signed add/subtract, clamp and the position register.

Test Plan:
- Reset -> x=160, y=120, buttons 0; packet 0x08,0x05,0x03 -> packet_valid one cycle after third strobe; x=165, y=117.
- Packet 0x18,0x9C,0x00 (dx=-100) from x=20 -> x=0 clamped; packet 0x08,0x7F,0x00 repeated until x=319, then once more -> x stays 319.
- Stray byte 0x00 before 0x09,0x00,0x00 -> sync_error pulse once; then left_down=1, left_click one pulse; repeating the packet -> no second left_click.
- 0x08,0x10 then idle TIMEOUT_CYCLES -> sync_error, no update; subsequent 0x08,0x01,0x01 -> x+1, y-1.
- Overflow: 0x48,0xFF,0x02 -> x unchanged, y-2; with MOUSE_ACCEL_EN, 0x08,0x0A,0x00 -> x+20, and 0x08,0x08,0x00 -> x+8.
- Reset asserted after second byte -> outputs return to init immediately; no packet_valid.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared FSM encoding, status-byte bit indices and packet length for the PS/2 mouse tracker
package ps2_mouse_pkg;
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} ps2_state_t;
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;
  localparam int PKT_LEN = 3;
endpackage

// File: rtl/ps2_axis_accum.sv
// ps2_axis_accum: one cursor axis - optional acceleration (MOUSE_ACCEL_EN), signed add/subtract, clamp, position register
module ps2_axis_accum #(
  parameter int WIDTH = 9,
  parameter int MAX = 319,
  parameter int INIT = 160,
  parameter bit DIR_NEG = 1'b0,
  parameter int ACCEL_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       i_delta,
  input  logic             i_ovf,
  input  logic             i_apply,
  output logic [WIDTH-1:0] o_pos
);
  localparam int SW = (WIDTH > 9 ? WIDTH : 9) + 3;
  localparam logic signed [SW-1:0] LMAX = SW'(MAX);
  logic [WIDTH-1:0] r_pos;
  logic signed [SW-1:0] w_d, w_step, w_pos, w_sum;
  logic [WIDTH-1:0] w_next;
  assign w_d = i_ovf ? '0 : {{(SW-9){i_delta[8]}}, i_delta};
`ifdef MOUSE_ACCEL_EN
  localparam logic signed [SW-1:0] THR = SW'(ACCEL_THRESH);
  logic signed [SW-1:0] w_mag;
  assign w_mag = w_d[SW-1] ? -w_d : w_d;
  assign w_step = (w_mag > THR) ? w_d <<< 1 : w_d;
`else
  assign w_step = w_d;
`endif
  // sum is wide enough for any (possibly doubled) 9-bit delta, so the clamp never sees a wrapped value
  assign w_pos = {{(SW-WIDTH){1'b0}}, r_pos};
  assign w_sum = DIR_NEG ? w_pos - w_step : w_pos + w_step;
  assign w_next = w_sum[SW-1] ? '0 : (w_sum > LMAX ? WIDTH'(MAX) : w_sum[WIDTH-1:0]);
  // position register, loaded only when a complete packet is applied
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pos <= WIDTH'(INIT);
    else if (i_apply) r_pos <= w_next;
  assign o_pos = r_pos;
endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: 3-byte PS/2 packet framing with timeout and clamped cursor tracking; MOUSE_ACCEL_EN enables acceleration
module ps2_mouse_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int X_WIDTH = 9,
  parameter int Y_WIDTH = 8,
  parameter int X_MAX = 319,
  parameter int Y_MAX = 239,
  parameter int X_INIT = 160,
  parameter int Y_INIT = 120,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ACCEL_THRESH = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         received_data,
  input  logic               received_data_en,
  output logic [X_WIDTH-1:0] x_position,
  output logic [Y_WIDTH-1:0] y_position,
  output logic               left_down,
  output logic               right_down,
  output logic               middle_down,
  output logic               left_click,
  output logic               packet_valid,
  output logic               sync_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_t r_state, w_next;
  logic [7:0] r_status, r_dx;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_btn;
  logic r_valid, r_click, r_sync;
  logic w_tmo, w_apply, w_sync;
  assign w_tmo = (r_state != WAIT_B0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // next state: a strobe always wins over a simultaneous timeout
  always_comb begin
    w_next = r_state;
    w_apply = 1'b0;
    w_sync = 1'b0;
    if (received_data_en) begin
      case (r_state)
        WAIT_B0: if (received_data[SYNC]) w_next = WAIT_B1; else w_sync = 1'b1;
        WAIT_B1: w_next = WAIT_B2;
        default: begin
          w_next = WAIT_B0;
          w_apply = 1'b1;
        end
      endcase
    end else if (w_tmo) begin
      w_next = WAIT_B0;
      w_sync = 1'b1;
    end
  end
  // state, byte latches and inter-byte idle counter
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      r_state <= WAIT_B0;
      r_status <= '0;
      r_dx <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT_B0 || received_data_en || w_tmo) ? '0 : r_cnt + 1'b1;
      if (received_data_en && r_state == WAIT_B0 && received_data[SYNC]) r_status <= received_data;
      if (received_data_en && r_state == WAIT_B1) r_dx <= received_data;
    end
  // buttons and one-cycle pulses, updated together with the position
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      r_btn <= '0;
      r_valid <= 1'b0;
      r_click <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_valid <= w_apply;
      r_sync <= w_sync;
      r_click <= w_apply & r_status[BTN_L] & ~r_btn[0];
      if (w_apply) r_btn <= {r_status[BTN_M], r_status[BTN_R], r_status[BTN_L]};
    end
  ps2_axis_accum #(.WIDTH(X_WIDTH), .MAX(X_MAX), .INIT(X_INIT), .DIR_NEG(1'b0), .ACCEL_THRESH(ACCEL_THRESH)) u_x (
    .clk(CLOCK_50), .rst(reset), .i_delta({r_status[XS], r_dx}), .i_ovf(r_status[XO]),
    .i_apply(w_apply), .o_pos(x_position)
  );
  ps2_axis_accum #(.WIDTH(Y_WIDTH), .MAX(Y_MAX), .INIT(Y_INIT), .DIR_NEG(1'b1), .ACCEL_THRESH(ACCEL_THRESH)) u_y (
    .clk(CLOCK_50), .rst(reset), .i_delta({r_status[YS], received_data}), .i_ovf(r_status[YO]),
    .i_apply(w_apply), .o_pos(y_position)
  );
  assign left_down = r_btn[0];
  assign right_down = r_btn[1];
  assign middle_down = r_btn[2];
  assign left_click = r_click;
  assign packet_valid = r_valid;
  assign sync_error = r_sync;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: directed-vector bench for ps2_mouse_tracker
module tb_ps2_mouse_tracker;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_data;
  logic rx_en;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic l_down, r_down, m_down, l_click, pkt_valid, sync_err;
  int n_checks = 0;
  int n_fail = 0;
  int pv_n = 0, sy_n = 0, ck_n = 0;
  int pv0, sy0, ck0;
  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(clk), .reset(rst), .received_data(rx_data), .received_data_en(rx_en),
    .x_position(x_pos), .y_position(y_pos), .left_down(l_down), .right_down(r_down),
    .middle_down(m_down), .left_click(l_click), .packet_valid(pkt_valid), .sync_error(sync_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (pkt_valid) pv_n++;
    if (sync_err) sy_n++;
    if (l_click) ck_n++;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_en = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk);
    rx_en = 1'b0;
  endtask
  task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c); idle();
  endtask
  task automatic snap();
    @(posedge clk);
    pv0 = pv_n; sy0 = sy_n; ck0 = ck_n;
  endtask
  task automatic settle();
    @(negedge clk);
    @(posedge clk);
  endtask
  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x", x_pos, 160);
    check("rst_y", y_pos, 120);
    check("rst_btn", {m_down, r_down, l_down}, 0);
    check("rst_pulses", {pkt_valid, sync_err, l_click}, 0);
    rst = 1'b0;
    pkt(8'h08, 8'h05, 8'h03);
    check("pv_latency", pkt_valid, 1);
    check("basic_x", x_pos, 165);
    check("basic_y", y_pos, 117);
    @(negedge clk);
    check("pv_one_cycle", pkt_valid, 0);
    pkt(8'h18, 8'h9C, 8'h00);
    check("neg_dx_x", x_pos, 65);
    pkt(8'h18, 8'h9C, 8'h00);
    check("clamp_x0", x_pos, 0);
    pkt(8'h08, 8'h00, 8'h7F);
    check("clamp_y0", y_pos, 0);
    pkt(8'h08, 8'h7F, 8'h00);
    pkt(8'h08, 8'h7F, 8'h00);
    check("x_254", x_pos, 254);
    pkt(8'h08, 8'h7F, 8'h00);
    check("clamp_xmax", x_pos, 319);
    pkt(8'h08, 8'h7F, 8'h00);
    check("stay_xmax", x_pos, 319);
    pkt(8'h28, 8'h00, 8'h80);
    check("neg_dy_y", y_pos, 128);
    pkt(8'h28, 8'h00, 8'h80);
    check("clamp_ymax", y_pos, 239);
    snap();
    send(8'h00);
    send(8'h09); send(8'h00); send(8'h00);
    send(8'h09); send(8'h00); send(8'h00);
    idle();
    settle();
    check("stray_sync_cnt", sy_n - sy0, 1);
    check("b2b_pv_cnt", pv_n - pv0, 2);
    check("click_once", ck_n - ck0, 1);
    check("left_down", l_down, 1);
    check("b2b_pos", {23'd0, x_pos}, 319);
    pkt(8'h18, 8'h9C, 8'h00);
    check("left_release", l_down, 0);
    check("x_219", x_pos, 219);
    snap();
    send(8'h08); send(8'h10); idle();
    repeat (TMO + 5) @(negedge clk);
    settle();
    check("tmo_sync_cnt", sy_n - sy0, 1);
    check("tmo_no_pv", pv_n - pv0, 0);
    check("tmo_x", x_pos, 219);
    pkt(8'h08, 8'h01, 8'h01);
    check("post_tmo_x", x_pos, 220);
    check("post_tmo_y", y_pos, 238);
    pkt(8'h48, 8'hFF, 8'h02);
    check("xovf_x", x_pos, 220);
    check("xovf_y", y_pos, 236);
    pkt(8'h88, 8'h05, 8'h7F);
    check("yovf_x", x_pos, 225);
    check("yovf_y", y_pos, 236);
    pkt(8'h03, 8'h00, 8'h00);
    check("nosync_btn", {m_down, r_down, l_down}, 0);
    pkt(8'h0E, 8'h00, 8'h00);
    check("rm_btn", {m_down, r_down, l_down}, 6);
`ifdef MOUSE_ACCEL_EN
    pkt(8'h08, 8'h0A, 8'h00);
    check("accel_x", x_pos, 245);
    pkt(8'h08, 8'h08, 8'h00);
    check("noaccel_x", x_pos, 253);
`endif
    snap();
    send(8'h08); send(8'h20); idle();
    #1 rst = 1'b1;
    #1;
    check("midrst_x", x_pos, 160);
    check("midrst_y", y_pos, 120);
    check("midrst_btn", {m_down, r_down, l_down}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    check("midrst_no_pv", pv_n - pv0, 0);
    pkt(8'h08, 8'h01, 8'h00);
    check("midrst_restart_x", x_pos, 161);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
